// File: rtl/msf_encoder.sv
// -----------------------------------------------------------------------------
// msf_encoder
//
// Builds the MSF carrier on/off sample stream from one data word per second.
// Each second is SPS samples long. A sample of 1 means carrier on and a sample
// of 0 means carrier off. The block is used as an on-chip test-pattern source
// and as loopback stimulus for the second decoder / sampler chain.
//
// Second words arrive through a one-entry valid/ready buffer ("pending"). At
// every second boundary (a sample tick while idx == 0) the pending word, if
// one is present, becomes the active word for that whole second. If nothing
// is pending, the second is transmitted as an idle second (carrier on
// throughout) and underrun_o is flagged on its first sample.
//
// Ports
//   clk_i           in   clock
//   rst_ni          in   asynchronous active-low reset
//   sample_tick_i   in   one-cycle strobe per sample period
//   sec_valid_i     in   second word offered
//   sec_ready_o     out  pending buffer is empty (registered)
//   sec_is_00_i     in   word is second 00 (minute marker); A/B ignored
//   sec_data_i      in   {B, A} data bits of the second
//   sample_valid_o  out  one-cycle pulse, new sample on sample_data_o
//   sample_data_o   out  carrier state, held between pulses
//   sec_start_o     out  pulses with the sample at index 0
//   underrun_o      out  pulses at index 0 when no word was pending
// -----------------------------------------------------------------------------
module msf_encoder #(
    parameter int SPS = 10
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       sample_tick_i,
    input  logic       sec_valid_i,
    output logic       sec_ready_o,
    input  logic       sec_is_00_i,
    input  logic [1:0] sec_data_i,
    output logic       sample_valid_o,
    output logic       sample_data_o,
    output logic       sec_start_o,
    output logic       underrun_o
);

    localparam logic [3:0] IDX_LAST = 4'(SPS - 1);

    // IDLE: no word active, every sample is carrier-on.
    // BUSY: a word was loaded at the last boundary and shapes this second.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] idx_q, idx_d;

    logic       pend_full_q, pend_full_d;
    logic       pend_is00_q, pend_is00_d;
    logic [1:0] pend_data_q, pend_data_d;

    logic       act_is00_q, act_is00_d;
    logic [1:0] act_data_q, act_data_d;

    logic       ready_q, ready_d;
    logic       smp_valid_q, smp_valid_d;
    logic       smp_data_q, smp_data_d;
    logic       start_q, start_d;
    logic       underrun_q, underrun_d;

    logic       xfer;
    logic       boundary;

    // Carrier state for sample k of a second.
    //   marker : off for the first five samples, then on
    //   data   : k=0 off, k=1 ~A, k=2 ~B, then on
    //   idle   : always on
    function automatic logic sample_value(input logic       busy,
                                          input logic       is00,
                                          input logic [1:0] data,
                                          input logic [3:0] k);
        logic v;
        v = 1'b1;
        if (busy) begin
            if (is00) begin
                v = (k >= 4'd5);
            end else begin
                case (k)
                    4'd0:    v = 1'b0;
                    4'd1:    v = ~data[0];
                    4'd2:    v = ~data[1];
                    default: v = 1'b1;
                endcase
            end
        end
        return v;
    endfunction

    assign xfer     = sec_valid_i && ready_q;
    assign boundary = sample_tick_i && (idx_q == 4'd0);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pend_full_d = pend_full_q;
        pend_is00_d = pend_is00_q;
        pend_data_d = pend_data_q;
        act_is00_d  = act_is00_q;
        act_data_d  = act_data_q;
        smp_valid_d = 1'b0;
        smp_data_d  = smp_data_q;
        start_d     = 1'b0;
        underrun_d  = 1'b0;

        if (sample_tick_i) begin
            idx_d = (idx_q == IDX_LAST) ? 4'd0 : idx_q + 4'd1;
        end

        if (boundary) begin
            if (pend_full_q) begin
                state_d     = ST_BUSY;
                act_is00_d  = pend_is00_q;
                act_data_d  = pend_data_q;
                pend_full_d = 1'b0;
            end else begin
                state_d     = ST_IDLE;
            end
        end

        // Transfers only happen while the buffer is empty, so this can never
        // overwrite a word being promoted above. A transfer on an empty
        // boundary waits in pending for the following boundary.
        if (xfer) begin
            pend_full_d = 1'b1;
            pend_is00_d = sec_is_00_i;
            pend_data_d = sec_data_i;
        end

        ready_d = !pend_full_d;

        // The next-state active word is used so that sample 0 already
        // reflects the word promoted at this boundary.
        if (sample_tick_i) begin
            smp_valid_d = 1'b1;
            smp_data_d  = sample_value(state_d == ST_BUSY, act_is00_d,
                                       act_data_d, idx_q);
            start_d     = (idx_q == 4'd0);
            underrun_d  = boundary && !pend_full_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            idx_q       <= 4'd0;
            pend_full_q <= 1'b0;
            pend_is00_q <= 1'b0;
            pend_data_q <= 2'b00;
            act_is00_q  <= 1'b0;
            act_data_q  <= 2'b00;
            ready_q     <= 1'b1;
            smp_valid_q <= 1'b0;
            smp_data_q  <= 1'b1;
            start_q     <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pend_full_q <= pend_full_d;
            pend_is00_q <= pend_is00_d;
            pend_data_q <= pend_data_d;
            act_is00_q  <= act_is00_d;
            act_data_q  <= act_data_d;
            ready_q     <= ready_d;
            smp_valid_q <= smp_valid_d;
            smp_data_q  <= smp_data_d;
            start_q     <= start_d;
            underrun_q  <= underrun_d;
        end
    end

    assign sec_ready_o    = ready_q;
    assign sample_valid_o = smp_valid_q;
    assign sample_data_o  = smp_data_q;
    assign sec_start_o    = start_q;
    assign underrun_o     = underrun_q;

endmodule
